// File: rtl/arb_requester.sv
// Requester side of the 3-way priority arbiter: per-client FSMs turn jobs into held requests.
// Optional request-wait abort is enabled by defining ARB_REQ_TIMEOUT_EN.
module arb_requester #(
    parameter int unsigned N        = 3,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N-1:0]       job_valid,
    input  logic [N*LEN_W-1:0] job_len,
    output logic [N-1:0]       job_ready,
    output logic [N-1:0]       r,
    input  logic [N-1:0]       g,
    output logic [N-1:0]       done,
    output logic [N-1:0]       timeout,
    output logic               grant_err
);

    typedef enum logic [1:0] {StIdle, StReq, StBusy, StGap} state_e;

    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);

    logic [N-1:0] busy;
    logic         grant_err_q, grant_err_d;

    for (genvar i = 0; i < N; i++) begin : g_client
        state_e           state_q, state_d;
        logic [LEN_W-1:0] cnt_q, cnt_d;
        logic [LEN_W-1:0] len_in;

        assign len_in = job_len[i*LEN_W +: LEN_W];

`ifdef ARB_REQ_TIMEOUT_EN
        localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
        localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

        logic [WaitW-1:0] wait_q, wait_d;
        logic             to_q, to_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            wait_d  = wait_q;
            to_d    = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (job_valid[i]) begin
                        state_d = StReq;
                        cnt_d   = (len_in == '0) ? LenOne : len_in;
                        wait_d  = '0;
                    end
                end
                StReq: begin
                    // A grant on the limit edge takes precedence over the abort.
                    if (g[i] && cnt_q != '0) begin
                        cnt_d   = cnt_q - LenOne;
                        state_d = (cnt_q == LenOne) ? StGap : StBusy;
                    end else if (wait_q == WaitLast) begin
                        state_d = StIdle;
                        to_d    = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                StBusy: begin
                    if (g[i] && cnt_q != '0) begin
                        cnt_d   = cnt_q - LenOne;
                        state_d = (cnt_q == LenOne) ? StGap : StBusy;
                    end
                end
                StGap:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                wait_q <= '0;
                to_q   <= 1'b0;
            end else begin
                wait_q <= wait_d;
                to_q   <= to_d;
            end
        end

        assign timeout[i] = to_q;
`else
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                StIdle: begin
                    if (job_valid[i]) begin
                        state_d = StReq;
                        cnt_d   = (len_in == '0) ? LenOne : len_in;
                    end
                end
                StReq, StBusy: begin
                    if (g[i] && cnt_q != '0) begin
                        cnt_d   = cnt_q - LenOne;
                        state_d = (cnt_q == LenOne) ? StGap : StBusy;
                    end
                end
                StGap:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        assign timeout[i] = 1'b0;
`endif

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign job_ready[i] = (state_q == StIdle);
        assign r[i]         = (state_q == StReq) || (state_q == StBusy);
        assign done[i]      = (state_q == StGap);
        assign busy[i]      = (state_q == StBusy);
    end

    // Multi-hot grant, grant without request, or grant withdrawn from a client mid-hold.
    assign grant_err_d = (|(g & (g - 1'b1))) | (|(g & ~r)) | (|(~g & busy));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_err_q <= 1'b0;
        end else begin
            grant_err_q <= grant_err_d;
        end
    end

    assign grant_err = grant_err_q;

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: job-level reference model plus directed scenarios.
module tb_arb_requester;

    localparam int N        = 3;
    localparam int LEN_W    = 4;
    localparam int MAX_WAIT = 16;

    logic             clk;
    logic             resetn;
    logic [N-1:0]     job_valid;
    logic [N*LEN_W-1:0] job_len;
    logic [N-1:0]     job_ready;
    logic [N-1:0]     r;
    logic [N-1:0]     g;
    logic [N-1:0]     done;
    logic [N-1:0]     timeout;
    logic             grant_err;

    arb_requester #(.N(N), .LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .job_valid (job_valid),
        .job_len   (job_len),
        .job_ready (job_ready),
        .r         (r),
        .g         (g),
        .done      (done),
        .timeout   (timeout),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Arbiter stand-in: 0 = grant one cycle after request, 1 = immediate, 2 = forced value.
    int           g_mode;
    logic [N-1:0] g_ovr;
    logic [N-1:0] r_prev;

    function automatic logic [N-1:0] pick(input logic [N-1:0] v);
        logic [N-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                p    = '0;
                p[i] = 1'b1;
            end
        end
        return p;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_prev <= '0;
        else         r_prev <= r;
    end

    always_comb begin
        case (g_mode)
            0:       g = pick(r & r_prev);
            1:       g = pick(r);
            default: g = g_ovr;
        endcase
    end

    // Reference model: remaining grant edges per job, plus gap/abort bookkeeping.
    int m_left[N];
    bit m_granted[N];
    bit m_gap[N];
    int m_wait[N];
    bit m_to[N];
    bit m_err;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_left[i] = 0; m_granted[i] = 0; m_gap[i] = 0; m_wait[i] = 0; m_to[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_step(input logic [N-1:0] jv, input logic [N*LEN_W-1:0] jl,
                              input logic [N-1:0] gs);
        bit err;
        int len;
        err = 0;
        if ($countones(gs) > 1) err = 1;
        for (int i = 0; i < N; i++) begin
            if (gs[i] && m_left[i] == 0) err = 1;
            if (!gs[i] && m_left[i] > 0 && m_granted[i]) err = 1;
        end
        for (int i = 0; i < N; i++) begin
            m_to[i] = 0;
            if (m_gap[i]) begin
                m_gap[i] = 0;
            end else if (m_left[i] == 0) begin
                if (jv[i]) begin
                    len = int'(jl[i*LEN_W +: LEN_W]);
                    m_left[i] = (len == 0) ? 1 : len;
                    m_granted[i] = 0;
                    m_wait[i] = 0;
                end
            end else if (gs[i]) begin
                m_left[i]--;
                m_granted[i] = 1;
                if (m_left[i] == 0) m_gap[i] = 1;
            end else if (!m_granted[i]) begin
`ifdef ARB_REQ_TIMEOUT_EN
                m_wait[i]++;
                if (m_wait[i] == MAX_WAIT) begin
                    m_left[i] = 0;
                    m_to[i] = 1;
                end
`endif
            end
        end
        m_err = err;
    endtask

    always @(negedge clk) begin
        logic [N-1:0] e_r, e_rdy, e_done, e_to;
        if (!resetn) model_reset();
        for (int i = 0; i < N; i++) begin
            e_r[i]    = (m_left[i] > 0);
            e_rdy[i]  = (m_left[i] == 0) && !m_gap[i];
            e_done[i] = m_gap[i];
            e_to[i]   = m_to[i];
        end
        check("r", 32'(r), 32'(e_r));
        check("job_ready", 32'(job_ready), 32'(e_rdy));
        check("done", 32'(done), 32'(e_done));
        check("timeout", 32'(timeout), 32'(e_to));
        check("grant_err", 32'(grant_err), 32'(m_err));
        if (resetn) model_step(job_valid, job_len, g);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    int hi, dn, ge, tc;
    int d0, d1, d2;
    int c0, c1, c2;
    logic [8:0] r_pat, rdy_pat;

    initial begin
        resetn = 1'b0; job_valid = '0; job_len = '0; g_mode = 2; g_ovr = '0;
        #2;
        check("reset_r", 32'(r), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_grant_err", 32'(grant_err), 32'h0);
        cyc(); cyc();
        resetn = 1'b1;
        #1;
        check("reset_ready", 32'(job_ready), 32'h7);
        drain(2);

        // Single job, grant returned one cycle after request.
        g_mode = 0;
        job_valid = 3'b001; job_len = 12'h003;
        cyc();
        job_valid = '0;
        hi = 0; dn = 0; ge = 0;
        for (int k = 0; k < 12; k++) begin
            if (r[0]) hi++;
            if (done[0]) dn++;
            if (grant_err) ge++;
            cyc();
        end
        check("t1_r_high_cycles", 32'(hi), 32'd4);
        check("t1_done_pulses", 32'(dn), 32'd1);
        check("t1_grant_err", 32'(ge), 32'd0);

        // Three simultaneous jobs serviced in priority order.
        job_valid = 3'b111; job_len = 12'h222;
        cyc();
        job_valid = '0;
        d0 = -1; d1 = -1; d2 = -1; c0 = 0; c1 = 0; c2 = 0; hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (r[0]) hi++;
            if (done[0]) begin c0++; if (d0 < 0) d0 = k; end
            if (done[1]) begin c1++; if (d1 < 0) d1 = k; end
            if (done[2]) begin c2++; if (d2 < 0) d2 = k; end
            cyc();
        end
        check("t2_done2_cycle", 32'(d2), 32'd3);
        check("t2_done1_cycle", 32'(d1), 32'd5);
        check("t2_done0_cycle", 32'(d0), 32'd7);
        check("t2_done_counts", {8'(c2), 8'(c1), 8'(c0)}, 32'h010101);
        check("t2_r0_high_cycles", 32'(hi), 32'd7);

        // Maximum length and zero length.
        job_valid = 3'b100; job_len = 12'hF00;
        cyc();
        job_valid = '0;
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (r[2]) hi++;
            cyc();
        end
        check("len15_r_high_cycles", 32'(hi), 32'd16);
        g_mode = 1;
        job_valid = 3'b100; job_len = 12'h000;
        cyc();
        job_valid = '0;
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            if (r[2]) hi++;
            cyc();
        end
        check("len0_r_high_cycles", 32'(hi), 32'd1);

        // Back-to-back length-1 jobs with immediate grant.
        job_valid = 3'b010; job_len = 12'h010;
        cyc();
        for (int k = 0; k < 9; k++) begin
            r_pat[k] = r[1];
            rdy_pat[k] = job_ready[1];
            cyc();
        end
        job_valid = '0;
        drain(4);
        check("t3_r1_pattern", 32'(r_pat), 32'h049);
        check("t3_ready1_pattern", 32'(rdy_pat), 32'h124);

        // Protocol violations on g.
        g_mode = 2;
        g_ovr = 3'b011;
        cyc();
        g_ovr = '0;
        check("t4_multihot_err", 32'(grant_err), 32'd1);
        cyc();
        check("t4_err_clears", 32'(grant_err), 32'd0);
        g_ovr = 3'b100;
        cyc();
        g_ovr = '0;
        check("t4_unrequested_err", 32'(grant_err), 32'd1);
        cyc();
        job_valid = 3'b010; job_len = 12'h030;
        cyc();
        job_valid = '0;
        g_ovr = 3'b010;
        cyc();
        g_ovr = '0;
        cyc();
        check("t4_stolen_err", 32'(grant_err), 32'd1);
        check("t4_stolen_r_held", 32'(r[1]), 32'd1);
        g_ovr = 3'b010;
        cyc();
        check("t4_resume_no_err", 32'(grant_err), 32'd0);
        check("t4_still_req", 32'(r[1]), 32'd1);
        cyc();
        g_ovr = '0;
        check("t4_released", 32'(r[1]), 32'd0);
        check("t4_done", 32'(done[1]), 32'd1);
        cyc();
        check("t4_gap_no_err", 32'(grant_err), 32'd0);
        drain(2);

        // Asynchronous reset in the middle of a held request.
        g_mode = 0;
        job_valid = 3'b001; job_len = 12'h005;
        cyc();
        job_valid = '0;
        drain(3);
        check("t5_busy_before_reset", 32'(r[0]), 32'd1);
        resetn = 1'b0;
        #1;
        check("t5_r_dropped", 32'(r), 32'h0);
        check("t5_no_done", 32'(done), 32'h0);
        cyc(); cyc();
        resetn = 1'b1;
        #1;
        check("t5_ready_after", 32'(job_ready), 32'h7);
        dn = 0;
        for (int k = 0; k < 6; k++) begin
            if (done != '0) dn++;
            cyc();
        end
        check("t5_no_late_done", 32'(dn), 32'd0);

`ifdef ARB_REQ_TIMEOUT_EN
        // Request abandoned after MAX_WAIT ungranted cycles, and a grant on the limit edge.
        g_mode = 2; g_ovr = '0;
        job_valid = 3'b001; job_len = 12'h002;
        cyc();
        job_valid = '0;
        hi = 0; tc = 0; dn = 0;
        for (int k = 0; k < 24; k++) begin
            if (r[0]) hi++;
            if (timeout[0]) tc++;
            if (done[0]) dn++;
            cyc();
        end
        check("t6_r_high_cycles", 32'(hi), 32'd16);
        check("t6_timeout_pulses", 32'(tc), 32'd1);
        check("t6_no_done", 32'(dn), 32'd0);
        job_valid = 3'b001; job_len = 12'h001;
        cyc();
        job_valid = '0;
        drain(15);
        g_ovr = 3'b001;
        cyc();
        g_ovr = '0;
        check("t6_limit_grant_done", 32'(done[0]), 32'd1);
        check("t6_limit_grant_no_to", 32'(timeout[0]), 32'd0);
        cyc();
        check("t6_no_late_timeout", 32'(timeout[0]), 32'd0);
        drain(3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
